// File: rtl/mux_sel_scanner_pkg.sv
// Shared definitions for the mux_4_to_1 select scanner: channel geometry and FSM state encoding.
package mux_sel_scanner_pkg;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned DEF_DWELL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4:1 multiplexer driven by the scanner's sel output.
module mux_4_to_1 (
    input  logic [3:0] i,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = i[sel];
    end

endmodule

// File: rtl/mux_sel_scanner_next_ch_finder.sv
// Combinational search for the lowest enabled channel strictly above cur.
module next_ch_finder
    import mux_sel_scanner_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W:0]    cur,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    // cur with its MSB set stands for index -1, so every enabled channel qualifies.
    always_comb begin
        next  = '0;
        found = 1'b0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (!found && mask[n] &&
                (cur[SEL_W] || (n > 32'(cur[SEL_W-1:0])))) begin
                next  = SEL_W'(n);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// Sequencer that walks mux sel across enabled channels, dwells, samples mux y and
// publishes one sweep word per accepted start.
module mux_sel_scanner
    import mux_sel_scanner_pkg::*;
#(
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0]   sel,
    input  logic               mux_y,
    output logic               busy,
    output logic [NUM_CH-1:0]  sweep,
    output logic               sweep_valid
);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [NUM_CH-1:0]  buffer;

    logic [SEL_W-1:0]   first_ch;
    logic               first_found;
    logic [SEL_W-1:0]   nxt_ch;
    logic               nxt_found;

    next_ch_finder u_first (
        .mask  (ch_mask),
        .cur   ('1),
        .next  (first_ch),
        .found (first_found)
    );

    next_ch_finder u_next (
        .mask  (mask_q),
        .cur   ({1'b0, sel}),
        .next  (nxt_ch),
        .found (nxt_found)
    );

    // The sweep_valid cycle is spent in IDLE with busy still high, so busy gates acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= '0;
            busy        <= 1'b0;
            sweep       <= '0;
            sweep_valid <= 1'b0;
            cnt         <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            buffer      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sweep_valid <= 1'b0;
                    if (start && first_found && !busy) begin
                        mask_q  <= ch_mask;
                        dwell_q <= dwell;
                        cnt     <= dwell;
                        sel     <= first_ch;
                        buffer  <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else begin
                        buffer[sel] <= mux_y;
                        if (nxt_found) begin
                            sel <= nxt_ch;
                            cnt <= dwell_q;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    sweep       <= buffer;
                    sweep_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
